// File: rtl/ryuki_mem_responder_if.sv
// Request/grant/response bus between a core port (master) and a memory
// responder (slave). Signal suffixes are from the responder's point of view.
interface ryuki_mem_responder_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) ();
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                    req_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    stall_i;
    logic                    gnt_o;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    err_o;
    logic [OUT_W-1:0]        outstanding_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, stall_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, outstanding_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, stall_i,
        output gnt_o, rvalid_o, rdata_o, err_o, outstanding_o
    );
endinterface

// File: rtl/ryuki_mem_responder.sv
// Memory slave for a core req/gnt/rvalid bus: programmable grant wait-states,
// fixed response latency, bounded outstanding requests, byte-enabled writes,
// an address window that answers with errors, and external stall injection.
module ryuki_mem_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int GNT_LATENCY     = 0,
    parameter int RVALID_LATENCY  = 1,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] ERR_BASE  = 32'hFFFF_0000,
    parameter logic [ADDR_WIDTH-1:0] ERR_LIMIT = 32'hFFFF_FFFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ryuki_mem_responder_if.slave  bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TMR_W = $clog2(RVALID_LATENCY + 1);
    localparam int CNT_W = (GNT_LATENCY > 1) ? $clog2(GNT_LATENCY) : 1;
    // Offset-based window test: one unsigned compare covers both bounds.
    localparam logic [ADDR_WIDTH-1:0] ERR_SPAN = ERR_LIMIT - ERR_BASE;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GRANT} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic [TMR_W-1:0]      timer;
    } resp_t;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    resp_t                 queue_q [MAX_OUTSTANDING];
    resp_t                 queue_d [MAX_OUTSTANDING];
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic                  full;
    logic                  grant_ok;
    logic                  gnt;
    logic                  pop;
    logic                  in_err;
    logic [IDX_W-1:0]      word_idx;
    logic [OUT_W-1:0]      push_idx;
    resp_t                 new_entry;

    // Full means no grant this cycle even if the head pops on the same edge.
    assign full     = (outstanding_q == OUT_W'(MAX_OUTSTANDING));
    assign grant_ok = bus.req_i & ~bus.stall_i & ~full;
    assign in_err   = (bus.addr_i - ERR_BASE) <= ERR_SPAN;
    assign word_idx = bus.addr_i[IDX_W+1:2];

    assign new_entry.rdata = (bus.we_i || in_err) ? '0 : mem_q[word_idx];
    assign new_entry.err   = in_err;
    assign new_entry.timer = TMR_W'(RVALID_LATENCY - 1);

    // Grant FSM: cnt counts the WAIT cycles still to go before GRANT.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (GNT_LATENCY == 0) begin
                    gnt = grant_ok;
                end else if (bus.req_i) begin
                    if (GNT_LATENCY == 1) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(GNT_LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.req_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_d == '0) state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt = grant_ok;
                // Stall or full keeps GRANT; no fresh wait states are added.
                if (!bus.req_i || grant_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response queue: age timers, pop a ready head, append the new response.
    always_comb begin
        queue_d       = queue_q;
        pop           = (outstanding_q != '0) && (queue_q[0].timer == '0);
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (OUT_W'(i) < outstanding_q && queue_q[i].timer != '0)
                queue_d[i].timer = queue_q[i].timer - 1'b1;
        end
        if (pop) begin
            for (int i = 0; i < MAX_OUTSTANDING - 1; i++) queue_d[i] = queue_d[i+1];
        end
        push_idx = outstanding_q - OUT_W'(pop);
        if (gnt) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (OUT_W'(i) == push_idx) queue_d[i] = new_entry;
            end
        end
        outstanding_d = outstanding_q + OUT_W'(gnt) - OUT_W'(pop);
    end

    // Control state, queue and registered response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) queue_q[i] <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_d;
            queue_q       <= queue_d;
            rvalid_q      <= pop;
            if (pop) begin
                rdata_q <= queue_q[0].rdata;
                err_q   <= queue_q[0].err;
            end
        end
    end

    // Byte-enabled write at the grant edge; error-window writes are dropped.
    always_ff @(posedge clk_i) begin
        // NOTE: the array deliberately has no reset so it maps to RAM and keeps its contents across rst_i.
        if (gnt && bus.we_i && !in_err) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.be_i[b]) mem_q[word_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
            end
        end
    end

    assign bus.gnt_o         = gnt;
    assign bus.rvalid_o      = rvalid_q;
    assign bus.rdata_o       = rdata_q;
    assign bus.err_o         = err_q;
    assign bus.outstanding_o = outstanding_q;
endmodule
